// File: rtl/scaled_multiplier_if.sv
// Start/done handshake and operand/result bundle for the scaled-format multiplier.
interface scaled_multiplier_if;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        ovf;

    modport master (
        output start, in1, in2,
        input  busy, done, out, ovf
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, out, ovf
    );
endinterface

// File: rtl/scaled_multiplier.sv
// Sequential signed shift-add multiplier for the 16-bit scaled word format
// (13-bit mantissa, 3-bit scale) with renormalisation and saturation.
module scaled_multiplier #(
    parameter int MANT_W    = 13,
    parameter int SCALE_MAX = 7
) (
    input  logic               clk,
    input  logic               rst,
    scaled_multiplier_if.slave bus
);
    localparam int ACC_W = 2 * MANT_W;
    localparam int P_W   = ACC_W + 1;

    typedef logic signed [P_W-1:0] prod_t;
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    localparam prod_t P_HI = prod_t'((2 ** (MANT_W - 1)) - 1);
    localparam prod_t P_LO = prod_t'(-(2 ** (MANT_W - 1)));

    state_t            state;
    state_t            state_nx;
    logic [MANT_W-1:0] mb;
    logic [ACC_W-1:0]  ma_sh;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nx;
    logic [3:0]        cnt;
    logic [3:0]        scale;
    logic              sign;
    prod_t             prod;
    prod_t             prod_mag;
    logic              fits;
    logic              shift;
    logic [15:0]       out_q;
    logic              ovf_q;

    function automatic logic [MANT_W-1:0] mag(input logic [MANT_W-1:0] m);
        return m[MANT_W-1] ? (~m) + MANT_W'(1) : m;
    endfunction

    assign acc_nx   = acc + (mb[0] ? ma_sh : '0);
    assign prod_mag = prod_t'({1'b0, acc_nx});
    assign fits     = (prod >= P_LO) && (prod <= P_HI);
    assign shift    = ((scale > 4'(SCALE_MAX)) || !fits) && (scale != 4'd0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = MUL;
            MUL:  if (cnt == 4'(MANT_W - 1)) state_nx = NORM;
            NORM: if (!shift) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mb    <= '0;
            ma_sh <= '0;
            acc   <= '0;
            cnt   <= '0;
            scale <= '0;
            sign  <= 1'b0;
            prod  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (bus.start) begin
                    ma_sh <= ACC_W'(mag(bus.in1[15:3]));
                    mb    <= mag(bus.in2[15:3]);
                    sign  <= bus.in1[15] ^ bus.in2[15];
                    scale <= {1'b0, bus.in1[2:0]} + {1'b0, bus.in2[2:0]};
                    acc   <= '0;
                    cnt   <= '0;
                end
                MUL: begin
                    acc   <= acc_nx;
                    ma_sh <= ma_sh << 1;
                    mb    <= mb >> 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'(MANT_W - 1))
                        prod <= sign ? -prod_mag : prod_mag;
                end
                NORM: begin
                    if (shift) begin
                        prod  <= prod >>> 1;
                        scale <= scale - 4'd1;
                    end else if (fits) begin
                        out_q <= {prod[MANT_W-1:0], scale[2:0]};
                        ovf_q <= 1'b0;
                    end else begin
                        // Scale exhausted: clamp to the extreme of the sign.
                        out_q <= {prod[P_W-1], {(MANT_W-1){~prod[P_W-1]}}, 3'd0};
                        ovf_q <= 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.out  = out_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_scaled_multiplier.sv
// Directed bench for scaled_multiplier: results, latency, handshake
// abuse and mid-operation reset.
module tb_scaled_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    scaled_multiplier_if bus();

    scaled_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Steps edges after the start edge until done; 0 means no done seen.
    task automatic wait_done(output int edge_n, output bit busy_ok);
        edge_n  = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_out,
                       input bit exp_ovf, input int exp_edge);
        int e;
        bit bok;
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(e, bok);
        check({tag, "_edge"}, e, exp_edge);
        check({tag, "_busy"}, 32'(bok), 1);
        check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle"}, 32'({bus.busy, bus.done}), 0);
    endtask

    initial begin
        int e;
        bit bok;
        bit saw;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_out", 32'(bus.out), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        run("mul_1p5x2", 16'h0019, 16'h0010, 16'h0031, 1'b0, 14);
        run("scale_red", 16'h000F, 16'h000F, 16'h0007, 1'b0, 21);
        run("neg_norm", 16'h8003, 16'h0010, 16'h8002, 1'b0, 15);
        run("sat_pos", 16'h7FF8, 16'h7FF8, 16'h7FF8, 1'b1, 14);
        run("sat_neg", 16'h8000, 16'h7FF8, 16'h8000, 1'b1, 14);

        // start held high, operands swapped right after they were sampled
        bus.in1   = 16'h0019;
        bus.in2   = 16'h0010;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in1 = 16'h7FF8;
        bus.in2 = 16'h7FF8;
        wait_done(e, bok);
        check("abuse_edge", e, 14);
        check("abuse_busy", 32'(bok), 1);
        check("abuse_out", 32'(bus.out), 32'h0031);
        check("abuse_ovf", 32'(bus.ovf), 0);
        @(posedge clk);
        @(negedge clk);
        check("abuse_gap", 32'({bus.busy, bus.done}), 0);
        @(posedge clk);
        @(negedge clk);
        check("abuse_restart", 32'(bus.busy), 1);
        bus.start = 1'b0;
        wait_done(e, bok);
        check("abuse2_edge", e, 14);
        check("abuse2_out", 32'(bus.out), 32'h7FF8);
        check("abuse2_ovf", 32'(bus.ovf), 1);
        @(posedge clk);
        @(negedge clk);

        // reset lands on the sixth MUL edge
        bus.in1   = 16'h0019;
        bus.in2   = 16'h0010;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_out", 32'(bus.out), 0);
        check("abort_ovf", 32'(bus.ovf), 0);
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check("abort_quiet", 32'(saw), 0);
        run("after_abort", 16'h0019, 16'h0010, 16'h0031, 1'b0, 14);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scaled_multiplier.md
Name: scaled_multiplier

Overview:
- Sequential signed multiplier for the ODE solver's 16-bit scaled word format.
- Word format: [15:3] is a signed 13-bit mantissa; [2:0] is the scale (number of fractional bits). Value = mantissa / 2^scale.
- Sits directly upstream of the adder: it produces the h·f(x,y) and coefficient-product terms that the adder sums.
- Computes the product with a shift-add multiply, then renormalises the result back into the 16-bit format with a start/done handshake.

Parameters:
- MANT_W, 13, mantissa width in bits (format fixed; changing it is unsupported).
- SCALE_MAX, 7, largest representable scale.

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   synchronous, active-high reset
- start  input   1   request; sampled only in IDLE
- in1    input   16  operand A, scaled format
- in2    input   16  operand B, scaled format
- busy   output  1   high in every state except IDLE
- done   output  1   one-cycle pulse; out and ovf are valid from this cycle
- out    output  16  product, scaled format; held until the next accepted start
- ovf    output  1   product saturated; held with out

Behaviour:
- Reset (rst=1 at an edge): state←IDLE; busy=0, done=0, out=16'h0000, ovf=0. Applies from any state and aborts an operation in flight; no done pulse is issued for the aborted operation.
- IDLE: start=1 at an edge does the following:
  - latch |mA|, |mB| as 13-bit unsigned values (|−4096| = 4096 fits);
  - latch sign = mA[12]^mB[12] and scale s = sA + sB (4-bit, 0..14);
  - clear the 26-bit accumulator and the counter; go to MUL.
- start while busy is ignored; operands are not re-sampled.
- MUL: one shift-add iteration per edge (LSB of multiplier first), 13 iterations.
  - On the 13th edge, apply the sign to the 26-bit accumulator (two's-complement negate if sign=1) into a signed 27-bit product P, then go to NORM.
- NORM, evaluated each edge. "fits" means −4096 ≤ P ≤ 4095.
  - (s > 7 or !fits) and s > 0: P ← P >>> 1 (arithmetic shift, truncation toward −∞); s ← s−1; stay in NORM.
  - Otherwise, if fits: out ← {P[12:0], s[2:0]}; ovf ← 0; go to DONE.
  - Otherwise (s = 0, does not fit): saturate. out ← {P<0 ? 13'h1000 : 13'h0FFF, 3'd0}; ovf ← 1; go to DONE.
  - Zero product: with s > 7 it still shifts down to s = 7; the result mantissa is 0.
- DONE: done=1 for exactly this cycle; next edge → IDLE. start in DONE is ignored.
- Latency: with k = number of NORM shifts (0..14), done is high in the cycle after edge 14+k, counted from the edge that sampled start.
  - Back-to-back: earliest next start is sampled one cycle after done.
- out/ovf change only on the NORM finalise edge and on reset.
- No combinational path from any input to any output.

Test Plan:
- 1.5·2.0: in1=16'h0019 (m=3, s=1), in2=16'h0010 (m=2, s=0), one-cycle start → out=16'h0031, ovf=0; done high exactly after edge 14 (k=0); busy high from edge 0 until done clears.
- Scale reduction: in1=16'h000F, in2=16'h000F (m=1, s=7 each; s=14) → 7 shifts, out=16'h0007 (m=0, s=7), ovf=0; done after edge 21.
- Negative mantissa normalisation: in1=16'h8003 (m=−4096, s=3), in2=16'h0010 (m=2) → P=−8192, 1 shift → out=16'h8002, ovf=0; done after edge 15.
- Saturation: in1=in2=16'h7FF8 (m=4095, s=0) → out=16'h7FF8, ovf=1. Repeat with in1=16'h8000 (m=−4096, s=0), in2=16'h7FF8 (m=4095, s=0) → out=16'h8000, ovf=1.
- Handshake abuse: start held high throughout and operands changed mid-MUL → only the first operands are used and the result matches case 1. A second start is accepted only one cycle after done; start pulses in MUL/NORM/DONE are ignored.
- Reset mid-operation: assert rst at edge 6 of MUL → next cycle busy=0, out=16'h0000, ovf=0, no done pulse. A new start after that gives a correct result.
